// File: rtl/dense_layer.sv
// Streaming fully connected layer: accumulates N_INPUTS fixed-point samples into one
// weighted sum per neuron, then presents rounded, saturated (optionally ReLU) results.
module dense_layer #(
    parameter int INTEGER_BITS     = 9,
    parameter int FIXED_POINT_BITS = 4,
    parameter int N_INPUTS         = 36,
    parameter int N_NEURONS        = 2,
    parameter int RELU_EN          = 1,
    localparam int W  = INTEGER_BITS + FIXED_POINT_BITS,
    localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
    localparam int IW = $clog2(N_INPUTS + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic signed [W-1:0]    in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   coef_wr_en,
    input  logic [NW-1:0]          coef_neuron,
    input  logic [IW-1:0]          coef_index,
    input  logic signed [W-1:0]    coef_data,
    output logic                   busy,
    output logic [W*N_NEURONS-1:0] neurons,
    output logic                   output_valid,
    input  logic                   output_ready
);

    localparam int F  = FIXED_POINT_BITS;
    localparam int CW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int AW = 2 * W + $clog2(N_INPUTS + 1);

    localparam logic [CW-1:0]        LAST    = CW'(N_INPUTS - 1);
    localparam logic signed [AW-1:0] ROUND   = (AW'(1) << F) >> 1;
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW - W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW - W + 1){1'b1}}, {(W - 1){1'b0}}};

    typedef enum logic {
        ACCUM,
        OUT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          take;
    logic          coef_ok;

    // Power-up contents are the configuration default of zero.
    logic signed [W-1:0] weight_mem [2**NW][2**CW];
    logic signed [W-1:0] bias_mem   [2**NW];

    function automatic logic signed [AW-1:0] bias_ext(input logic signed [W-1:0] b);
        return $signed({{(AW - W){b[W-1]}}, b}) <<< F;
    endfunction

    function automatic logic signed [AW-1:0] mac(input logic signed [AW-1:0] base,
                                                 input logic signed [W-1:0]  w,
                                                 input logic signed [W-1:0]  x);
        logic signed [2*W-1:0] prod;
        prod = $signed({{W{w[W-1]}}, w}) * $signed({{W{x[W-1]}}, x});
        return base + $signed({{(AW - 2 * W){prod[2*W-1]}}, prod});
    endfunction

    // Round half up, drop the fraction, clamp to the word range, then optional ReLU.
    function automatic logic [W-1:0] quantize(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] scaled;
        logic [W-1:0]         q;
        scaled = (acc + ROUND) >>> F;
        if (scaled > SAT_MAX)      q = SAT_MAX[W-1:0];
        else if (scaled < SAT_MIN) q = SAT_MIN[W-1:0];
        else                       q = scaled[W-1:0];
        if (RELU_EN != 0 && q[W-1]) q = '0;
        return q;
    endfunction

    assign in_ready     = (state_q == ACCUM);
    assign output_valid = (state_q == OUT);
    assign busy         = (cnt_q != '0) || (state_q == OUT);
    assign take         = in_valid && in_ready;
    assign coef_ok      = coef_wr_en && !busy &&
                          (int'(coef_neuron) < N_NEURONS) && (int'(coef_index) <= N_INPUTS);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (take && cnt_q == LAST) state_d = OUT;
            OUT:     if (output_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is asynchronous and acts without a clock.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (take) cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // NOTE: coefficient storage deliberately has no reset so it maps onto plain RAM
    // and survives a reset of the datapath.
    always_ff @(posedge i_clk) begin
        if (coef_ok) begin
            if (int'(coef_index) == N_INPUTS) bias_mem[coef_neuron] <= coef_data;
            else weight_mem[coef_neuron][coef_index[CW-1:0]] <= coef_data;
        end
    end

    for (genvar k = 0; k < N_NEURONS; k++) begin : g_neuron
        logic signed [AW-1:0] acc_q;
        logic signed [AW-1:0] acc_d;
        logic [W-1:0]         result_q;

        // The first sample of a frame starts from the bias instead of the old sum.
        assign acc_d = mac((cnt_q == '0) ? bias_ext(bias_mem[k]) : acc_q,
                           weight_mem[k][cnt_q], in_data);

        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                acc_q    <= '0;
                result_q <= '0;
            end else if (take) begin
                acc_q <= acc_d;
                if (cnt_q == LAST) result_q <= quantize(acc_d);
            end
        end

        assign neurons[W*k +: W] = result_q;
    end

endmodule
